// File: rtl/freq_meter.sv
// Gate-window frequency counter.
// Counts the rising edges of an asynchronous input over a fixed window of GATE_CYCLES clocks
// and reports the count. It saturates at the counter limit and flags that in overflow.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned GATE_W      = 27,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

  localparam logic [GATE_W-1:0] GateLast = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  state_e state_q, state_d;

  logic              s1_q, s2_q, s3_q;
  logic              rise;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic              ovf_q;
  logic              gate_last;
  logic              win_clr;

  // Three-flop chain: s1/s2 resolve metastability, s3 delays s2 for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise      = s2_q & ~s3_q;
  assign gate_last = (gate_cnt_q == GateLast);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. win_clr marks every entry into a fresh gate window.
  always_comb begin
    state_d = state_q;
    win_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start || continuous) begin
          state_d = StGate;
          win_clr = 1'b1;
        end
      end
      StGate: begin
        // start is deliberately ignored here: no restart mid-window.
        if (gate_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (continuous) begin
          state_d = StGate;
          win_clr = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gate and edge counters. Edges are counted only in GATE, so a rise in DONE is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else if (win_clr) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else if (state_q == StGate) begin
      gate_cnt_q <= gate_cnt_q + 1'b1;
      if (rise) begin
        if (edge_cnt_q == CntMax) begin
          ovf_q <= 1'b1;
        end else begin
          edge_cnt_q <= edge_cnt_q + 1'b1;
        end
      end
    end
  end

  // Registered outputs: the result is latched in DONE and becomes visible one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out   <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= (state_q == StDone);
      busy       <= (state_d == StGate);
      if (state_q == StDone) begin
        freq_out <= edge_cnt_q;
        overflow <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a main instance (8-bit count) and a saturating instance
// (3-bit count) share every input.
module tb_freq_meter;

  logic       clk;
  logic       rst_n;
  logic       sig_in;
  logic       start;
  logic       continuous;
  logic [7:0] freq_out;
  logic       freq_valid;
  logic       overflow;
  logic       busy;
  logic [2:0] sat_freq_out;
  logic       sat_freq_valid;
  logic       sat_overflow;
  logic       sat_busy;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int sig_period = 0;
  int phase;
  int cyc, bsy, busy_seen, vbase;

  freq_meter #(.GATE_CYCLES(100), .GATE_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  freq_meter #(.GATE_CYCLES(100), .GATE_W(8), .CNT_W(3)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .freq_out   (sat_freq_out),
    .freq_valid (sat_freq_valid),
    .overflow   (sat_overflow),
    .busy       (sat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count result pulses away from the active edge.
  always @(negedge clk) begin
    if (freq_valid) valid_cnt <= valid_cnt + 1;
  end

  // Periodic sig_in: sig_period clocks, first half high; 0 means hold low.
  initial begin
    sig_in = 1'b0;
    phase  = 0;
    forever begin
      @(negedge clk);
      if (sig_period == 0) begin
        sig_in = 1'b0;
        phase  = 0;
      end else begin
        sig_in = (phase < sig_period / 2);
        phase  = (phase + 1 >= sig_period) ? 0 : phase + 1;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Optionally pulse start, then wait (bounded) for freq_valid; optionally spam start every 7.
  task automatic measure(input bit do_start, input bit spam, output int n_cyc, output int n_bsy);
    n_cyc = 0;
    n_bsy = 0;
    if (do_start) start = 1'b1;
    while (n_cyc < 400) begin
      tick();
      n_cyc++;
      if (busy) n_bsy++;
      start = spam && (n_cyc % 7 == 0);
      if (freq_valid) break;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    busy_seen  = 0;

    // Reset state.
    repeat (3) tick();
    check("rst_freq_out", int'(freq_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(freq_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 200 cycles: nothing happens.
    repeat (200) begin
      tick();
      if (busy) busy_seen++;
    end
    check("idle_valid_pulses", valid_cnt, 0);
    check("idle_busy_cycles", busy_seen, 0);
    check("idle_freq_out", int'(freq_out), 0);

    // Single measurement, period 10: 10 edges; the 3-bit instance saturates at 7.
    sig_period = 10;
    repeat (20) tick();
    vbase = valid_cnt;
    measure(1'b1, 1'b0, cyc, bsy);
    check("single_latency", cyc, 102);
    check("single_busy_len", bsy, 100);
    check("single_freq_out", int'(freq_out), 10);
    check("single_overflow", int'(overflow), 0);
    check("sat_freq_out", int'(sat_freq_out), 7);
    check("sat_overflow", int'(sat_overflow), 1);
    tick();
    check("single_valid_width", int'(freq_valid), 0);
    check("single_busy_after", int'(busy), 0);
    repeat (30) tick();
    check("single_one_pulse", valid_cnt - vbase, 1);
    check("single_hold", int'(freq_out), 10);

    // Constant sig_in window clears the result and the overflow flag.
    sig_period = 0;
    repeat (10) tick();
    measure(1'b1, 1'b0, cyc, bsy);
    check("zero_freq_out", int'(freq_out), 0);
    check("zero_overflow", int'(overflow), 0);
    check("zero_sat_freq_out", int'(sat_freq_out), 0);
    check("zero_sat_overflow", int'(sat_overflow), 0);

    // Continuous mode, period 4: 25 per window, 101-cycle result spacing.
    sig_period = 4;
    repeat (10) tick();
    continuous = 1'b1;
    measure(1'b0, 1'b0, cyc, bsy);
    check("cont1_latency", cyc, 102);
    check("cont1_freq_out", int'(freq_out), 25);
    measure(1'b0, 1'b0, cyc, bsy);
    check("cont2_interval", cyc, 101);
    check("cont2_freq_out", int'(freq_out), 25);
    check("cont2_sat_overflow", int'(sat_overflow), 1);
    repeat (50) tick();
    continuous = 1'b0;
    measure(1'b0, 1'b0, cyc, bsy);
    check("cont_drop_remaining", cyc, 51);
    check("cont_drop_freq_out", int'(freq_out), 25);
    tick();
    vbase     = valid_cnt;
    busy_seen = 0;
    repeat (30) begin
      tick();
      if (busy) busy_seen++;
    end
    check("cont_drop_idle_busy", busy_seen, 0);
    check("cont_drop_no_more_valid", valid_cnt - vbase, 0);

    // Reset at gate cycle 50 aborts the window and clears the old result.
    sig_period = 10;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    check("mid_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_freq_out", int'(freq_out), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(freq_valid), 0);
    vbase = valid_cnt;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) tick();
    check("mid_rst_no_valid", valid_cnt - vbase, 0);
    check("mid_rst_idle_busy", int'(busy), 0);
    measure(1'b1, 1'b0, cyc, bsy);
    check("post_rst_latency", cyc, 102);
    check("post_rst_busy_len", bsy, 100);
    check("post_rst_freq_out", int'(freq_out), 10);

    // Start spam during GATE: still one 100-cycle window and one result.
    repeat (10) tick();
    vbase = valid_cnt;
    measure(1'b1, 1'b1, cyc, bsy);
    check("spam_latency", cyc, 102);
    check("spam_busy_len", bsy, 100);
    check("spam_freq_out", int'(freq_out), 10);
    busy_seen = 0;
    repeat (40) begin
      tick();
      if (busy) busy_seen++;
    end
    check("spam_one_result", valid_cnt - vbase, 1);
    check("spam_no_rearm", busy_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gate-window frequency counter: the inverse of the board's clock divider.
- Counts rising edges of an asynchronous input `sig_in` over a fixed window of `GATE_CYCLES` `clk` cycles, then reports the count (= Hz when the window is 1 s).
- Used to check divided/scan clocks and external signals on the board; the result feeds the 7-segment display path.

Parameters:
- GATE_CYCLES, 100000000: gate window length in `clk` cycles (1 s at 100 MHz). Must be ≥ 2.
- GATE_W, 27: width of the gate counter; must satisfy 2^GATE_W > GATE_CYCLES.
- CNT_W, 27: width of the edge counter and of `freq_out`.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- sig_in  input  1  measured signal, asynchronous to `clk`
- start  input  1  single-cycle request to begin one measurement
- continuous  input  1  1 = re-arm automatically after each result
- freq_out  output  CNT_W  last completed edge count, held until next result
- freq_valid  output  1  one-cycle pulse when `freq_out` updates
- overflow  output  1  last result saturated; updates with `freq_out`
- busy  output  1  high while in GATE state

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - state = IDLE
  - synchronizer flops = 0
  - gate counter = 0, edge counter = 0
  - freq_out = 0, freq_valid = 0, overflow = 0, busy = 0
- Input synchronizer: 3-flop chain s1→s2→s3. Rising edge `rise = s2 & ~s3`, one `clk` cycle wide.
  - Latency from a `sig_in` rising edge to `rise` is 2–3 cycles.
  - Pulses shorter than one `clk` period may be missed; this is allowed.
- FSM states: IDLE, GATE, DONE.
- IDLE:
  - On `start` = 1 or `continuous` = 1, go to GATE next cycle.
  - Gate counter and edge counter are cleared on this transition.
- GATE:
  - Lasts exactly GATE_CYCLES cycles; gate counter runs 0 .. GATE_CYCLES-1.
  - Edge counter increments on every cycle with `rise` = 1, including the first and last GATE cycles.
  - When the edge counter is at 2^CNT_W-1, further rises do not wrap; the sticky internal overflow flag is set instead.
  - When the gate counter = GATE_CYCLES-1, go to DONE.
  - `start` is ignored in this state; there is no restart.
- DONE (exactly one cycle):
  - `freq_out` ← edge count; `overflow` ← sticky flag.
  - `freq_valid` = 1 for this cycle only. These are registered outputs, visible in the cycle after DONE is entered.
  - Next state is GATE (counters cleared) if `continuous` = 1, otherwise IDLE.
- Back-to-back continuous windows have a 1-cycle gap (the DONE cycle); a `rise` in the DONE cycle is not counted.
- `busy` = 1 exactly while state = GATE (registered).
- `start` and `continuous` both asserted in IDLE: single entry to GATE, no double start.
- `continuous` deasserted mid-window: the current window completes and reports, then the FSM goes to IDLE.
- `rst_n` asserted mid-window: the measurement is aborted and no `freq_valid` is produced. The previous `freq_out` is lost (reads 0).
- `sig_in` held constant for a whole window: result 0, `overflow` = 0.

Test Plan (GATE_CYCLES = 100, GATE_W = 8, CNT_W = 8 unless noted):
- Reset then idle: release `rst_n`, hold `start` = 0 for 200 cycles → freq_out = 0, freq_valid never pulses, busy = 0.
- Single measurement, `sig_in` period 10 clk (5 high / 5 low), edges aligned away from window boundaries:
  - `start` pulse → busy high for exactly 100 cycles.
  - One freq_valid pulse; freq_out = 10, overflow = 0.
  - busy returns to 0 and freq_out holds 10.
- Continuous mode with `continuous` = 1 and `sig_in` period 4 clk:
  - freq_valid pulses every 101 cycles; each freq_out = 25 (±1 at boundaries).
  - Drop `continuous` mid-window → that window still reports, then IDLE.
- Saturation with CNT_W = 3 and `sig_in` period 10 clk: freq_out = 7, overflow = 1. Next window with `sig_in` = 0 → freq_out = 0, overflow = 0.
- Reset mid-window:
  - Assert `rst_n` = 0 at gate cycle 50 → freq_out = 0, busy = 0 immediately, no freq_valid.
  - After release, a new `start` gives a normal full-window result.
- `start` spam: pulse `start` every 7 cycles during GATE → exactly one result per window, window length still 100.
